barrett_operand_multiplier: RTL and testbench

- Pipelined K x K coefficient multiplier with valid/ready handshake.
- Sits directly upstream of the Barrett reduction stage and feeds it the 2K-bit product x.
- Splits operand b into low/high halves and sums the partial products in a fixed 3-stage pipeline.
- A single global stall freezes the pipeline under downstream backpressure.

---
 rtl/barrett_operand_multiplier_pkg.sv | 23 ++
 rtl/barrett_operand_multiplier_mult_partial_product.sv | 31 +++
 rtl/barrett_operand_multiplier.sv | 156 +++++++++++++++
 tb/tb_barrett_operand_multiplier.sv | 274 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/barrett_operand_multiplier_pkg.sv
// ============================================================================
// Module      : barrett_operand_multiplier_pkg
// Description : Shared constants and types for the coefficient datapath.
//               The multiplier and the downstream Barrett reduction stage
//               both use these. The coefficient type is K bits wide and the
//               product type is 2K bits wide.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package barrett_operand_multiplier_pkg;

    localparam int unsigned Q_DEFAULT     = 65537;
    localparam int unsigned K_DEFAULT     = $clog2(Q_DEFAULT);
    localparam int unsigned SPLIT_DEFAULT = K_DEFAULT / 2;
    localparam int unsigned PROD_W        = 2 * K_DEFAULT;

    typedef logic [K_DEFAULT-1:0] coeff_t;
    typedef logic [PROD_W-1:0]    prod_t;

endpackage : barrett_operand_multiplier_pkg

`default_nettype wire

// File: rtl/barrett_operand_multiplier_mult_partial_product.sv
// ============================================================================
// Module      : mult_partial_product
// Description : Purely combinational unsigned multiplier. It forms the
//               product of a full-width operand and one slice of the other
//               operand. The top module uses two instances, one for each
//               half of b.
// Ports       : a [A_W] - full operand
//               b [B_W] - operand slice
//               p [A_W+B_W] - exact product a*b
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module mult_partial_product
    import barrett_operand_multiplier_pkg::*;
#(
    parameter int unsigned A_W = K_DEFAULT,
    parameter int unsigned B_W = SPLIT_DEFAULT
) (
    input  logic [A_W-1:0]     a,
    input  logic [B_W-1:0]     b,
    output logic [A_W+B_W-1:0] p
);

    // Both operands are widened to the result width first, so the
    // multiplication is exact and never truncates.
    assign p = (A_W+B_W)'(a) * (A_W+B_W)'(b);

endmodule : mult_partial_product

`default_nettype wire

// File: rtl/barrett_operand_multiplier.sv
// ============================================================================
// Module      : barrett_operand_multiplier
// Description : 3-stage pipelined K x K coefficient multiplier with a
//               valid/ready handshake. It feeds the 2K-bit product to the
//               Barrett reduction stage. Operand b is split into low and
//               high halves, and the two partial products are summed in
//               stage 2. One global enable freezes the whole pipeline
//               while the output is held.
// Ports       : clk, rst_n (async, active low), flush (sync valid clear)
//               in_valid/in_ready, a, b  - operand pair handshake
//               out_valid/out_ready, x   - product handshake
//               occupancy                - number of valid stages (0..3)
//               range_err                - sticky operand >= Q flag
// Config      : OPERAND_CHECK_EN - when defined, adds the range comparators
//               and the sticky range_err flag. When it is not defined,
//               range_err is tied to 0.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module barrett_operand_multiplier
    import barrett_operand_multiplier_pkg::*;
#(
    parameter int unsigned Q     = Q_DEFAULT,
    parameter int unsigned K     = $clog2(Q),
    parameter int unsigned SPLIT = K / 2
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic           flush,
    input  logic           in_valid,
    output logic           in_ready,
    input  logic [K-1:0]   a,
    input  logic [K-1:0]   b,
    output logic           out_valid,
    input  logic           out_ready,
    output logic [2*K-1:0] x,
    output logic [1:0]     occupancy,
    output logic           range_err
);

    localparam int unsigned c_hi_w = K - SPLIT;
    localparam int unsigned c_pw   = 2 * K;

    // These checks run at elaboration. They reject a Q that does not fit in
    // K bits and a split that leaves one half empty.
    if (64'(Q) > (64'd1 << K)) begin : g_bad_q
        $error("barrett_operand_multiplier: Q does not fit in K bits");
    end
    if ((SPLIT == 0) || (SPLIT >= K)) begin : g_bad_split
        $error("barrett_operand_multiplier: SPLIT must be in [1, K-1]");
    end

    logic                  w_en;
    logic                  r_v1;
    logic                  r_v2;
    logic                  r_out_valid;
    logic [K+SPLIT-1:0]    w_p_lo;
    logic [K+c_hi_w-1:0]   w_p_hi;
    logic [K+SPLIT-1:0]    r_p_lo;
    logic [K+c_hi_w-1:0]   r_p_hi;
    logic [c_pw-1:0]       w_sum;
    logic [c_pw-1:0]       r_sum;
    logic [c_pw-1:0]       r_x;

    // The pipeline moves only when the output register is empty or is
    // draining this cycle. Bubbles are not squeezed out.
    assign w_en     = !r_out_valid || out_ready;
    assign in_ready = w_en;

    mult_partial_product #(
        .A_W (K),
        .B_W (SPLIT)
    ) u_pp_lo (
        .a (a),
        .b (b[SPLIT-1:0]),
        .p (w_p_lo)
    );

    mult_partial_product #(
        .A_W (K),
        .B_W (c_hi_w)
    ) u_pp_hi (
        .a (a),
        .b (b[K-1:SPLIT]),
        .p (w_p_hi)
    );

    // The high partial product has weight 2^SPLIT. Its shifted value stays
    // below 2^(2K), so the sum is exact in c_pw bits.
    assign w_sum = c_pw'(r_p_lo) + (c_pw'(r_p_hi) << SPLIT);

    // Valid chain. Flush clears it even while the pipeline is stalled, and
    // it overrides an input arriving in the same cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (flush) begin
            r_v1        <= 1'b0;
            r_v2        <= 1'b0;
            r_out_valid <= 1'b0;
        end else if (w_en) begin
            r_v1        <= in_valid;
            r_v2        <= r_v1;
            r_out_valid <= r_v2;
        end
    end

    // Data registers follow the enable alone. Flush does not touch them.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_p_lo <= '0;
            r_p_hi <= '0;
            r_sum  <= '0;
            r_x    <= '0;
        end else if (w_en) begin
            r_p_lo <= w_p_lo;
            r_p_hi <= w_p_hi;
            r_sum  <= w_sum;
            r_x    <= r_sum;
        end
    end

    assign out_valid = r_out_valid;
    assign x         = r_x;
    assign occupancy = {1'b0, r_v1} + {1'b0, r_v2} + {1'b0, r_out_valid};

`ifdef OPERAND_CHECK_EN
    // Widened by one bit so Q can be compared even when it equals 2^K.
    localparam logic [K:0] c_q = (K+1)'(Q);

    logic w_out_of_range;
    logic r_range_err;

    assign w_out_of_range = ({1'b0, a} >= c_q) || ({1'b0, b} >= c_q);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_range_err <= 1'b0;
        end else if (flush) begin
            r_range_err <= 1'b0;
        end else if (in_valid && w_en && w_out_of_range) begin
            r_range_err <= 1'b1;
        end
    end

    assign range_err = r_range_err;
`else
    assign range_err = 1'b0;
`endif

endmodule : barrett_operand_multiplier

`default_nettype wire

// File: tb/tb_barrett_operand_multiplier.sv
// ============================================================================
// Module      : tb_barrett_operand_multiplier
// Description : Self-checking bench for barrett_operand_multiplier. Each
//               accepted pair pushes its expected product onto a scoreboard
//               queue. A monitor pops and compares whenever a product
//               transfers. Hand-written sequences cover latency,
//               backpressure, flush, reset mid-operation and the range flag.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_barrett_operand_multiplier;

    localparam int K = 17;

`ifdef OPERAND_CHECK_EN
    localparam logic EXP_RANGE_FLAG = 1'b1;
`else
    localparam logic EXP_RANGE_FLAG = 1'b0;
`endif

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic           flush = 1'b0;
    logic           in_valid = 1'b0;
    logic           in_ready;
    logic [K-1:0]   a = '0;
    logic [K-1:0]   b = '0;
    logic           out_valid;
    logic           out_ready = 1'b1;
    logic [2*K-1:0] x;
    logic [1:0]     occupancy;
    logic           range_err;

    int             n_checks = 0;
    int             n_fail   = 0;
    int             cyc      = 0;
    logic [63:0]    exp_q[$];

    typedef struct {
        logic [K-1:0] va;
        logic [K-1:0] vb;
        logic [63:0]  prod;
    } vec_t;

    vec_t vecs[8];

    barrett_operand_multiplier dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .flush     (flush),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .x         (x),
        .occupancy (occupancy),
        .range_err (range_err)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Scoreboard monitor. Inputs change just after posedge and this samples
    // at negedge, so a transfer seen here completes on the next posedge.
    always @(negedge clk) begin
        if (rst_n && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("out_unexpected_qsize", 64'(exp_q.size()), 64'd1);
            end else begin
                check("x_scoreboard", 64'(x), exp_q.pop_front());
            end
        end
    end

    // Called just after a posedge. Returns just after the posedge that
    // accepted the pair.
    task automatic send(input logic [K-1:0] ta, input logic [K-1:0] tbv, input logic [63:0] e);
        bit done = 1'b0;
        in_valid = 1'b1;
        a        = ta;
        b        = tbv;
        for (int n = 0; n < 100 && !done; n++) begin
            @(negedge clk);
            if (in_ready) begin
                exp_q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        if (!done) check("send_timeout", 64'(done), 64'd1);
    endtask

    task automatic drain();
        int n = 0;
        while (exp_q.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        @(posedge clk);
        #1;
        check("drain_qsize", 64'(exp_q.size()), 64'd0);
    endtask

    // The capture edge counts as the first of the three stage edges, so
    // out_valid is seen at the third negedge after the capture edge.
    task automatic check_latency(input string tag);
        @(negedge clk);
        check({tag, "_ov_edge1"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_ov_edge2"}, 64'(out_valid), 64'd0);
        @(negedge clk);
        check({tag, "_ov_edge3"}, 64'(out_valid), 64'd1);
        @(negedge clk);
        check({tag, "_occ_empty"}, 64'(occupancy), 64'd0);
        @(posedge clk);
        #1;
    endtask

    initial begin
        int c0;
        logic [K-1:0] ra;
        logic [K-1:0] rb;

        vecs[0] = '{17'd3,     17'd5,     64'd15};
        vecs[1] = '{17'd65536, 17'd65536, 64'd4294967296};
        vecs[2] = '{17'd0,     17'd12345, 64'd0};
        vecs[3] = '{17'd1,     17'd65536, 64'd65536};
        vecs[4] = '{17'd255,   17'd256,   64'd65280};
        vecs[5] = '{17'd65535, 17'd2,     64'd131070};
        vecs[6] = '{17'd46341, 17'd46341, 64'd2147488281};
        vecs[7] = '{17'd300,   17'd257,   64'd77100};

        // Reset state
        #2;
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_x",         64'(x),         64'd0);
        check("rst_occupancy", 64'(occupancy), 64'd0);
        check("rst_range_err", 64'(range_err), 64'd0);
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("idle_in_ready", 64'(in_ready), 64'd1);

        // Basic test with exact latency
        send(17'd3, 17'd5, 64'd15);
        check_latency("basic");
        drain();

        // Table vectors, sent back to back
        for (int i = 0; i < 8; i++) send(vecs[i].va, vecs[i].vb, vecs[i].prod);
        drain();

        // Random streaming: one accept per cycle
        c0 = cyc;
        for (int i = 0; i < 10; i++) begin
            ra = 17'($urandom_range(0, 65536));
            rb = 17'($urandom_range(0, 65536));
            send(ra, rb, 64'(ra) * 64'(rb));
        end
        check("stream_cycles", 64'(cyc - c0), 64'd10);
        drain();

        // Backpressure
        out_ready = 1'b0;
        fork
            begin
                send(17'd11,    17'd13,    64'd143);
                send(17'd100,   17'd200,   64'd20000);
                send(17'd65535, 17'd65535, 64'd4294836225);
                send(17'd4,     17'd4,     64'd16);
            end
            begin
                repeat (4) @(negedge clk);
                check("bp_in_ready",  64'(in_ready),  64'd0);
                check("bp_out_valid", 64'(out_valid), 64'd1);
                check("bp_occupancy", 64'(occupancy), 64'd3);
                check("bp_x_first",   64'(x),         64'd143);
                repeat (2) @(negedge clk);
                check("bp_x_held",    64'(x),         64'd143);
                check("bp_occ_held",  64'(occupancy), 64'd3);
                @(posedge clk);
                #1;
                out_ready = 1'b1;
            end
        join
        drain();

        // Flush: two pairs in flight, then flush together with in_valid
        in_valid = 1'b1; a = 17'd1; b = 17'd1;
        @(posedge clk); #1;
        a = 17'd2; b = 17'd2;
        @(negedge clk);
        check("flush_pre_occ", 64'(occupancy), 64'd1);
        @(posedge clk); #1;
        a = 17'd3; b = 17'd3; flush = 1'b1;
        @(negedge clk);
        check("flush_in_ready", 64'(in_ready), 64'd1);
        @(posedge clk); #1;
        flush = 1'b0; in_valid = 1'b0;
        @(negedge clk);
        check("flush_occ", 64'(occupancy), 64'd0);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            check("flush_no_out", 64'(out_valid), 64'd0);
        end
        @(posedge clk); #1;
        send(17'd7, 17'd9, 64'd63);
        drain();

        // Reset while three products are in flight
        in_valid = 1'b1; a = 17'd5; b = 17'd6;
        @(posedge clk); #1;
        a = 17'd7; b = 17'd8;
        @(posedge clk); #1;
        a = 17'd9; b = 17'd10;
        @(posedge clk); #1;
        in_valid = 1'b0;
        check("rstmid_pre_occ", 64'(occupancy), 64'd3);
        rst_n = 1'b0;
        #1;
        check("rstmid_out_valid", 64'(out_valid), 64'd0);
        check("rstmid_x",         64'(x),         64'd0);
        check("rstmid_occ",       64'(occupancy), 64'd0);
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk); #1;
        send(17'd2, 17'd2, 64'd4);
        check_latency("post_rst");
        drain();

        // Operand range flag
        send(17'd65537, 17'd1, 64'd65537);
        check("range_err_set", 64'(range_err), 64'(EXP_RANGE_FLAG));
        drain();
        repeat (2) @(posedge clk);
        #1;
        check("range_err_sticky", 64'(range_err), 64'(EXP_RANGE_FLAG));
        flush = 1'b1;
        @(posedge clk); #1;
        flush = 1'b0;
        check("range_err_flush", 64'(range_err), 64'd0);

        repeat (3) @(posedge clk);
        check("final_qsize", 64'(exp_q.size()), 64'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

endmodule : tb_barrett_operand_multiplier

`default_nettype wire
